// File: rtl/dotprod_mem_feeder.sv
// Feeder/collector for the dotprod kernel: buffers (a,b) element pairs, starts the
// kernel, serves its a/b memory ports with 1-cycle reads and returns the result.

module feeder_mem_port #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [31:0]   ld_data_i,
  input  logic          run_i,
  input  logic          ce_i,
  input  logic          we_i,
  input  logic [31:0]   addr_i,
  input  logic [31:0]   ad_i,
  output logic [31:0]   q_o
);
  logic [31:0] mem [DEPTH];
  logic [31:0] q_q;
  logic        in_range;

  assign in_range = addr_i < 32'(DEPTH);
  assign q_o      = q_q;

  // Load-side and kernel-side writes are mutually exclusive by FSM state.
  always_ff @(posedge clk) begin
    if (ld_we_i)
      mem[ld_addr_i] <= ld_data_i;
    else if (run_i && ce_i && we_i && in_range)
      mem[addr_i[AW-1:0]] <= ad_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      q_q <= '0;
    else if (run_i && ce_i && !we_i)
      q_q <= in_range ? mem[addr_i[AW-1:0]] : '0;
  end
endmodule

module dotprod_mem_feeder #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [31:0] res_count,
  output logic        res_err,
  output logic        k_start,
  input  logic        k_idle,
  input  logic        k_done,
  input  logic [31:0] k_return_val,
  output logic [31:0] k_n,
  input  logic [31:0] a_address0,
  input  logic        a_ce0,
  input  logic        a_we0,
  input  logic [31:0] a_ad0,
  output logic [31:0] a_q0,
  input  logic [31:0] b_address0,
  input  logic        b_ce0,
  input  logic        b_we0,
  input  logic [31:0] b_ad0,
  output logic [31:0] b_q0
);
  typedef enum logic [1:0] {S_LOAD, S_RUN, S_RESULT} state_t;

  state_t      state_q;
  logic [AW:0] wptr_q;
  logic        k_start_q;
  logic [31:0] k_n_q;
  logic [31:0] wd_q;
  logic [31:0] res_data_q;
  logic [31:0] res_count_q;
  logic        res_err_q;

  logic        hs;
  logic        last_d;
  logic [AW:0] wptr_d;
  logic        unused_k_idle;

  assign unused_k_idle = k_idle;

  assign in_ready  = (state_q == S_LOAD) && sys_rst_n;
  assign res_valid = (state_q == S_RESULT);
  assign res_data  = res_data_q;
  assign res_count = res_count_q;
  assign res_err   = res_err_q;
  assign k_start   = k_start_q;
  assign k_n       = k_n_q;

  assign hs     = in_valid && in_ready;
  assign wptr_d = wptr_q + (AW+1)'(1);
  // The last free slot truncates the vector even without in_last.
  assign last_d = in_last || (wptr_q == (AW+1)'(DEPTH-1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_LOAD;
      wptr_q      <= '0;
      k_start_q   <= 1'b0;
      k_n_q       <= '0;
      wd_q        <= '0;
      res_data_q  <= '0;
      res_count_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (hs) begin
            wptr_q <= wptr_d;
            if (last_d) begin
              k_n_q     <= 32'(wptr_d);
              wd_q      <= '0;
              k_start_q <= 1'b1;
              state_q   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (k_done) begin
            res_data_q  <= k_return_val;
            res_count_q <= k_n_q;
            res_err_q   <= 1'b0;
            k_start_q   <= 1'b0;
            state_q     <= S_RESULT;
          end else if (wd_q == 32'(TIMEOUT-1)) begin
            res_data_q  <= '0;
            res_count_q <= k_n_q;
            res_err_q   <= 1'b1;
            k_start_q   <= 1'b0;
            state_q     <= S_RESULT;
          end else if (wd_q != '1) begin
            wd_q <= wd_q + 32'd1;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            wptr_q  <= '0;
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Lane 0 serves memory a, lane 1 memory b.
  logic [1:0]       p_ce, p_we;
  logic [1:0][31:0] p_addr, p_ad, p_q, ld_data;

  assign p_ce    = {b_ce0, a_ce0};
  assign p_we    = {b_we0, a_we0};
  assign p_addr  = {b_address0, a_address0};
  assign p_ad    = {b_ad0, a_ad0};
  assign ld_data = {in_b, in_a};
  assign a_q0    = p_q[0];
  assign b_q0    = p_q[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    feeder_mem_port #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .ld_we_i   (hs),
      .ld_addr_i (wptr_q[AW-1:0]),
      .ld_data_i (ld_data[gi]),
      .run_i     (state_q == S_RUN),
      .ce_i      (p_ce[gi]),
      .we_i      (p_we[gi]),
      .addr_i    (p_addr[gi]),
      .ad_i      (p_ad[gi]),
      .q_o       (p_q[gi])
    );
  end
endmodule
